fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the DLX pipeline. Owns the program counter and decides each cycle whether it advances by 4, holds for a hazard stall, or reloads from a branch/jump redirect or trap vector. Drives the single-outstanding-request instruction-memory port and loads the IF/ID register. Sits between the hazard unit, the EX-stage branch resolution and instruction memory.

---
 rtl/fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_fetch_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: DLX instruction-fetch sequencer owning the PC, the imem request port and the IF/ID register
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rdy,
    input  logic [31:0] i_imem_rdata,
    output logic        o_flush,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_pc_out
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    localparam logic [31:0] W_RESET_PC = RESET_VECTOR & 32'hFFFF_FFFC;

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_skid, w_skid;
    logic [31:0] r_pending, w_pending;
    logic        r_if_valid, w_if_valid;
    logic [31:0] r_if_instr, w_if_instr;
    logic [31:0] r_if_pc, w_if_pc;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign o_flush     = i_trap | i_redirect_valid;
    assign w_target    = (i_trap ? TRAP_VECTOR : i_redirect_pc) & 32'hFFFF_FFFC;
    assign w_pc_inc    = r_pc + 32'd4;
    assign o_imem_req  = (r_state == FETCH) || (r_state == DRAIN);
    assign o_imem_addr = r_pc;
    assign o_pc_out    = r_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_instr  = r_if_instr;
    assign o_if_pc     = r_if_pc;

    // Next-state, PC, skid, pending-target and IF/ID selection
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_skid     = r_skid;
        w_pending  = r_pending;
        w_if_valid = r_if_valid;
        w_if_instr = r_if_instr;
        w_if_pc    = r_if_pc;
        case (r_state)
            BOOT: begin
                w_state    = FETCH;
                w_pc       = W_RESET_PC;
                w_if_valid = 1'b0;
            end
            FETCH: begin
                if (o_flush) begin
                    w_if_valid = 1'b0;
                    w_state    = i_imem_rdy ? FETCH : DRAIN;
                    w_pc       = i_imem_rdy ? w_target : r_pc;
                    w_pending  = i_imem_rdy ? r_pending : w_target;
                end else if (i_imem_rdy && !i_stall) begin
                    w_if_valid = 1'b1;
                    w_if_instr = i_imem_rdata;
                    w_if_pc    = r_pc;
                    w_pc       = w_pc_inc;
                end else if (i_imem_rdy) begin
                    w_skid  = i_imem_rdata;
                    w_state = HOLD;
                end else if (!i_stall) begin
                    w_if_valid = 1'b0;
                end
            end
            HOLD: begin
                if (o_flush) begin
                    w_if_valid = 1'b0;
                    w_pc       = w_target;
                    w_state    = FETCH;
                end else if (!i_stall) begin
                    w_if_valid = 1'b1;
                    w_if_instr = r_skid;
                    w_if_pc    = r_pc;
                    w_pc       = w_pc_inc;
                    w_state    = FETCH;
                end
            end
            DRAIN: begin
                w_if_valid = 1'b0;
                w_pending  = o_flush ? w_target : r_pending;
                if (i_imem_rdy) begin
                    w_pc    = w_pending;
                    w_state = FETCH;
                end
            end
            default: w_state = BOOT;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= BOOT;
            r_pc       <= W_RESET_PC;
            r_skid     <= 32'd0;
            r_pending  <= 32'd0;
            r_if_valid <= 1'b0;
            r_if_instr <= 32'd0;
            r_if_pc    <= 32'd0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_skid     <= w_skid;
            r_pending  <= w_pending;
            r_if_valid <= w_if_valid;
            r_if_instr <= w_if_instr;
            r_if_pc    <= w_if_pc;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized check of fetch_ctrl against a behavioural fetch model
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall, rv, trap, rdy;
    logic [31:0] rpc, rdata;
    logic        imem_req, flush, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc, pc_out;

    int total = 0;
    int bad = 0;

    // Behavioural model: boot flag, held-instruction queue, optional pending redirect
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    bit          m_pend_ok;
    logic [31:0] m_pend;
    bit          m_v;
    logic [31:0] m_instr, m_ifpc;

    fetch_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_redirect_valid(rv),
        .i_redirect_pc(rpc), .i_trap(trap), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdy(rdy), .i_imem_rdata(rdata), .o_flush(flush), .o_if_valid(if_valid),
        .o_if_instr(if_instr), .o_if_pc(if_pc), .o_pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        tgt = (trap ? 32'h100 : rpc) & 32'hFFFF_FFFC;
        if (reset) begin
            m_boot = 1; m_pc = 0; m_held.delete(); m_pend_ok = 0;
            m_v = 0; m_instr = 0; m_ifpc = 0;
        end else if (m_boot) begin
            m_boot = 0; m_v = 0;
        end else if (m_pend_ok) begin
            m_v = 0;
            if (trap || rv) m_pend = tgt;
            if (rdy) begin m_pc = m_pend; m_pend_ok = 0; end
        end else if (m_held.size() != 0) begin
            if (trap || rv) begin m_v = 0; m_held.delete(); m_pc = tgt; end
            else if (!stall) begin m_v = 1; m_instr = m_held.pop_front(); m_ifpc = m_pc; m_pc += 4; end
        end else if (trap || rv) begin
            m_v = 0;
            if (rdy) m_pc = tgt;
            else begin m_pend_ok = 1; m_pend = tgt; end
        end else if (rdy) begin
            if (stall) m_held.push_back(rdata);
            else begin m_v = 1; m_instr = rdata; m_ifpc = m_pc; m_pc += 4; end
        end else if (!stall) m_v = 0;
    endtask

    task automatic step(input bit r, input bit s, input bit v, input logic [31:0] p,
                        input bit t, input bit y, input logic [31:0] d);
        @(negedge clk);
        reset = r; stall = s; rv = v; rpc = p; trap = t; rdy = y; rdata = d;
        #1;
        chk("flush", {31'd0, flush}, {31'd0, t | v});
        chk("imem_req", {31'd0, imem_req}, {31'd0, !m_boot && m_held.size() == 0});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_out", pc_out, m_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
        if (m_v) begin
            chk("if_instr", if_instr, m_instr);
            chk("if_pc", if_pc, m_ifpc);
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall = 0; rv = 0; rpc = 0; trap = 0; rdy = 0; rdata = 0;
        m_boot = 1; m_pc = 0; m_pend_ok = 0; m_pend = 0; m_v = 0; m_instr = 0; m_ifpc = 0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", {31'd0, if_valid}, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_ifpc", if_pc, 0);
        step(0, 0, 0, 0, 0, 1, 32'hBAD0);
        chk("boot_exit_req", {31'd0, imem_req}, 1);
        chk("first_addr", imem_addr, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, 32'hA000_0000 + imem_addr);
            chk("seq_addr", imem_addr, 32'(4 * (i + 1)));
            chk("seq_ifpc", if_pc, 32'(4 * i));
            chk("seq_valid", {31'd0, if_valid}, 1);
        end
        step(0, 1, 0, 0, 0, 1, 32'hDEAD_0010);
        chk("hold_req", {31'd0, imem_req}, 0);
        chk("hold_ifpc", if_pc, 32'hC);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("hold_frozen", if_instr, 32'hA000_000C);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("skid_instr", if_instr, 32'hDEAD_0010);
        chk("skid_pc", if_pc, 32'h10);
        chk("resume_addr", imem_addr, 32'h14);
        step(0, 0, 1, 32'h203, 0, 1, 32'h1);
        chk("redir_valid", {31'd0, if_valid}, 0);
        chk("redir_addr", imem_addr, 32'h200);
        step(0, 0, 1, 32'h40, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain_addr", imem_addr, 32'h200);
        chk("drain_req", {31'd0, imem_req}, 1);
        step(0, 0, 0, 0, 0, 1, 32'hFEED);
        chk("trap_addr", imem_addr, 32'h100);
        chk("drain_valid", {31'd0, if_valid}, 0);
        step(0, 0, 1, 32'hFFFF_FFFF, 0, 1, 0);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 1, 32'h77);
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
        step(0, 0, 1, 32'h80, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_req", {31'd0, imem_req}, 0);
        chk("mid_rst_valid", {31'd0, if_valid}, 0);
        chk("mid_rst_pc", pc_out, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("restart_req", {31'd0, imem_req}, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                 $urandom, $urandom_range(15) == 0, $urandom_range(1) == 1, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
